spi_master_ctrl: RTL and testbench

//  SPI master that drives the SPI slave + single-port RAM subsystem from the other end of the link.

---
 rtl/spi_master_ctrl.sv | 159 +++++++++++++++
 tb/tb_spi_master_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// SPI master: serialises {cmd, payload} frames onto SS_n/MOSI and, for read-data
// commands, captures the slave's reply byte from MISO after a fixed turnaround.
// state    | meaning
// ST_IDLE  | SS_n high, ready for a command
// ST_SEL   | SS_n low, first (select) bit on MOSI
// ST_SHIFT | frame bits out MSB first
// ST_WAIT  | slave read turnaround, MOSI low
// ST_RECV  | MISO captured MSB first
// ST_GAP   | SS_n high between frames
`timescale 1ns/1ps
module spi_master_ctrl #(
   parameter int ADDR_SIZE  = 8,
   parameter int RD_LATENCY = 2,
   parameter int GAP_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [1:0]           req_cmd,
   input  logic [ADDR_SIZE-1:0] req_data,
   output logic                 rsp_valid,
   output logic [ADDR_SIZE-1:0] rsp_data,
   output logic                 busy,
   output logic                 SS_n,
   output logic                 MOSI,
   input  logic                 MISO
);

   localparam int FRAME_W = ADDR_SIZE + 2;
   localparam int CNT_W   = 16;
   localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FRAME_W - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'((RD_LATENCY > 0) ? RD_LATENCY - 1 : 0);
   localparam logic [CNT_W-1:0] RECV_LAST  = CNT_W'(ADDR_SIZE - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEL,
      ST_SHIFT,
      ST_WAIT,
      ST_RECV,
      ST_GAP
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [FRAME_W-1:0]     frame_q, frame_d;
   logic                   rd_q, rd_d;
   logic [ADDR_SIZE-1:0]   rx_q, rx_d;
   logic [ADDR_SIZE-1:0]   rsp_data_q, rsp_data_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic                   ss_n_c;
   logic                   mosi_c;

   assign req_ready = (state_q == ST_IDLE) && !rst;
   assign busy      = (state_q != ST_IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign SS_n      = ss_n_c;
   assign MOSI      = mosi_c;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      frame_d     = frame_q;
      rd_d        = rd_q;
      rx_d        = rx_q;
      rsp_data_d  = rsp_data_q;
      rsp_valid_d = 1'b0;
      ss_n_c      = 1'b1;
      mosi_c      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready) begin
               frame_d = {req_cmd, req_data};
               rd_d    = (req_cmd == 2'b11);
               state_d = ST_SEL;
            end
         end
         ST_SEL: begin
            ss_n_c  = 1'b0;
            mosi_c  = frame_q[FRAME_W-1];
            cnt_d   = SHIFT_LAST;
            state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            ss_n_c  = 1'b0;
            mosi_c  = frame_q[FRAME_W-1];
            frame_d = {frame_q[FRAME_W-2:0], 1'b0};
            if (cnt_q == '0) begin
               if (!rd_q) begin
                  cnt_d   = GAP_LAST;
                  state_d = ST_GAP;
               end else if (RD_LATENCY > 0) begin
                  cnt_d   = WAIT_LAST;
                  state_d = ST_WAIT;
               end else begin
                  cnt_d   = RECV_LAST;
                  state_d = ST_RECV;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_WAIT: begin
            ss_n_c = 1'b0;
            if (cnt_q == '0) begin
               cnt_d   = RECV_LAST;
               state_d = ST_RECV;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RECV: begin
            ss_n_c = 1'b0;
            rx_d   = {rx_q[ADDR_SIZE-2:0], MISO};
            if (cnt_q == '0) begin
               // publish the full byte together with SS_n release
               rsp_data_d  = {rx_q[ADDR_SIZE-2:0], MISO};
               rsp_valid_d = 1'b1;
               cnt_d       = GAP_LAST;
               state_d     = ST_GAP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_GAP: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         frame_q     <= '0;
         rd_q        <= 1'b0;
         rx_q        <= '0;
         rsp_data_q  <= '0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         frame_q     <= frame_d;
         rd_q        <= rd_d;
         rx_q        <= rx_d;
         rsp_data_q  <= rsp_data_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: frame shapes, read capture, reset abort,
// back-to-back spacing, with MISO noise outside the receive window.
`timescale 1ns/1ps
module tb_spi_master_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_cmd;
   logic [7:0] req_data;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       busy;
   logic       SS_n;
   logic       MOSI;
   logic       MISO;

   int n_chk = 0;
   int n_bad = 0;

   spi_master_ctrl #(.ADDR_SIZE(8), .RD_LATENCY(2), .GAP_CYCLES(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_cmd   (req_cmd),
      .req_data  (req_data),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .busy      (busy),
      .SS_n      (SS_n),
      .MOSI      (MOSI),
      .MISO      (MISO)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Cycle k=1 is the SEL cycle right after the accepting edge; read frames
   // drive miso_byte MSB first on k=14..21, every other cycle gets noise.
   task automatic run_frame(input string tag, input logic [1:0] cmd, input logic [7:0] data,
                            input logic [7:0] miso_byte, input int rst_at,
                            input logic [7:0] exp_rsp);
      int          len;
      int          n;
      logic [31:0] ss_vec, ss_exp, rv_vec, rv_exp;
      logic [10:0] mosi_seq;
      logic [9:0]  frame;
      logic        tail_err, busy_first, busy_last;
      len      = (cmd == 2'b11) ? 21 : 11;
      frame    = {cmd, data};
      ss_vec   = '1;
      rv_vec   = '0;
      mosi_seq = '0;
      tail_err = 1'b0;
      busy_first = 1'b0;
      busy_last  = 1'b1;
      @(negedge clk);
      req_cmd   = cmd;
      req_data  = data;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_cmd   = ~cmd;
      req_data  = ~data;
      for (int k = 1; k <= len + 2; k++) begin
         @(negedge clk);
         if (rst_at > 0 && k == rst_at + 1) begin
            chk({tag, "_rst_ssn"}, 32'(SS_n), 32'd1);
            chk({tag, "_rst_busy"}, 32'(busy), 32'd0);
            chk({tag, "_rst_ready_in_rst"}, 32'(req_ready), 32'd0);
            chk({tag, "_rst_rspv"}, 32'(rsp_valid), 32'd0);
            chk({tag, "_rst_rspd"}, 32'(rsp_data), 32'h00);
            rst = 1'b0;
            #1;
            chk({tag, "_rst_ready_after"}, 32'(req_ready), 32'd1);
            return;
         end
         ss_vec[k] = SS_n;
         rv_vec[k] = rsp_valid;
         if (k <= 11) mosi_seq = {mosi_seq[9:0], MOSI};
         else if (k <= len && MOSI) tail_err = 1'b1;
         if (k == 1) busy_first = busy;
         if (k == len + 2) busy_last = busy;
         if (cmd == 2'b11 && k >= 14 && k <= 21) MISO = miso_byte[21-k];
         else MISO = 1'($urandom_range(0, 1));
         if (rst_at > 0 && k == rst_at) rst = 1'b1;
      end
      ss_exp = '1;
      for (int k = 1; k <= len; k++) ss_exp[k] = 1'b0;
      rv_exp = (cmd == 2'b11) ? (32'd1 << (len + 1)) : 32'd0;
      chk({tag, "_ssn_shape"}, ss_vec, ss_exp);
      chk({tag, "_mosi_bits"}, 32'(mosi_seq), 32'({frame[9], frame}));
      chk({tag, "_rspv_pulse"}, rv_vec, rv_exp);
      chk({tag, "_rspd"}, 32'(rsp_data), 32'(exp_rsp));
      chk({tag, "_busy_sel"}, 32'(busy_first), 32'd1);
      chk({tag, "_busy_idle"}, 32'(busy_last), 32'd0);
      if (cmd == 2'b11) chk({tag, "_mosi_tail"}, 32'(tail_err), 32'd0);
   endtask

   task automatic run_b2b();
      int   acc, lows, run, min_gap, max_gap;
      logic prev_ss;
      acc = 0; lows = 0; run = 0; min_gap = 99; max_gap = 0; prev_ss = 1'b1;
      @(negedge clk);
      req_cmd   = 2'b00;
      req_data  = 8'h11;
      req_valid = 1'b1;
      for (int c = 0; c < 60; c++) begin
         if (!SS_n) begin
            if (prev_ss) begin
               if (lows > 0) begin
                  if (run < min_gap) min_gap = run;
                  if (run > max_gap) max_gap = run;
               end
               lows++;
            end
            run = 0;
         end else begin
            run++;
         end
         prev_ss = SS_n;
         if (req_valid && req_ready) begin
            acc++;
            if (acc == 3) begin
               @(posedge clk);
               #1;
               req_valid = 1'b0;
            end
         end
         @(negedge clk);
      end
      chk("b2b_accepts", 32'(acc), 32'd3);
      chk("b2b_frames", 32'(lows), 32'd3);
      chk("b2b_min_gap", 32'(min_gap), 32'd2);
      chk("b2b_max_gap", 32'(max_gap), 32'd2);
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_cmd   = 2'b00;
      req_data  = 8'h00;
      MISO      = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ssn", 32'(SS_n), 32'd1);
      chk("rst_mosi", 32'(MOSI), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rspv", 32'(rsp_valid), 32'd0);
      chk("rst_rspd", 32'(rsp_data), 32'h00);
      rst = 1'b0;
      #1;
      chk("rst_ready_rel", 32'(req_ready), 32'd1);

      run_frame("wa_3c", 2'b00, 8'h3C, 8'h00, 0, 8'h00);
      run_frame("wd_a5", 2'b01, 8'hA5, 8'h00, 0, 8'h00);
      run_frame("ra_3c", 2'b10, 8'h3C, 8'h00, 0, 8'h00);
      run_frame("rd_a5", 2'b11, 8'h00, 8'hA5, 0, 8'hA5);
      run_frame("rd_5a", 2'b11, 8'hFF, 8'h5A, 0, 8'h5A);
      run_frame("wa_c3", 2'b00, 8'hC3, 8'h00, 0, 8'h5A);
      run_frame("abort", 2'b01, 8'hA5, 8'h00, 6, 8'h00);
      run_b2b();
      run_frame("rd_81", 2'b11, 8'h3C, 8'h81, 0, 8'h81);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
